// File: rtl/sram_l1_pkg.sv
// Shared widths, read latency and FSM state encodings for the L1 SRAM wrapper.
package sram_l1_pkg;

    localparam int NUM_WMASKS_DEF   = 4;
    localparam int DATA_WIDTH_DEF   = 33;
    localparam int ADDR_WIDTH_DEF   = 9;
    localparam int READ_LATENCY_DEF = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WRITE     = 2'd1;
    localparam state_t ST_READ_WAIT = 2'd2;
    localparam state_t ST_DONE      = 2'd3;

endpackage

// File: rtl/sram_l1_array.sv
// Flop-based storage array with byte write enables, per-entry valid bits
// and an asynchronous (combinational) read port.
module sram_l1_array
    import sram_l1_pkg::*;
#(
    parameter int NUM_WMASKS = NUM_WMASKS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-2:0]   wdata,
    input  logic [NUM_WMASKS-1:0]   wmask,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-2:0]   rdata,
    output logic                    rvalid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-2:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [DATA_WIDTH-2:0] old_data;
    logic [DATA_WIDTH-2:0] merged;

    // An invalid entry contributes zeros for the bytes a write leaves unmasked.
    always_comb begin
        old_data = valid[waddr] ? mem[waddr] : '0;
        merged   = old_data;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[waddr] <= 1'b1;
        end
    end

    // Data bits are never reset; the valid bits alone decide what reads return.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= merged;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid[raddr];

endmodule

// File: rtl/l1_sram_wrap.sv
// L1 SRAM wrapper: csb/we command FSM, emulated read latency and
// registered read outputs around the storage array.
module l1_sram_wrap
    import sram_l1_pkg::*;
#(
    parameter int NUM_WMASKS   = NUM_WMASKS_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    csb,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-2:0]   data_in,
    input  logic [NUM_WMASKS-1:0]   wmask,
    output logic [DATA_WIDTH-2:0]   data_out,
    output logic                    data_ready
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-2:0] arr_rdata;
    logic                  arr_rvalid;

    // rst_n is active-high; the write strobe is suppressed on a reset edge.
    assign wr_en = (state == ST_IDLE) && !csb && !we && !rst_n;

    sram_l1_array #(
        .NUM_WMASKS (NUM_WMASKS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst_n),
        .wr_en  (wr_en),
        .waddr  (addr),
        .wdata  (data_in),
        .wmask  (wmask),
        .raddr  (rd_addr),
        .rdata  (arr_rdata),
        .rvalid (arr_rvalid)
    );

    // WRITE and DONE wait for csb to rise so a held csb never re-issues a command.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rd_addr    <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!csb) begin
                        if (!we) begin
                            state <= ST_WRITE;
                        end else begin
                            rd_addr <= addr;
                            cnt     <= CNT_W'(READ_LATENCY - 1);
                            state   <= ST_READ_WAIT;
                        end
                    end
                end
                ST_WRITE: begin
                    if (csb) begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    if (cnt == '0) begin
                        data_out   <= arr_rvalid ? arr_rdata : '0;
                        data_ready <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (csb) begin
                        data_ready <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_sram_wrap.sv
// Scoreboard bench: reads push expected data and completion cycle,
// a negedge monitor pops on each rising data_ready and compares.
module tb_l1_sram_wrap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csb;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data_in;
    logic [3:0]  wmask;
    logic [31:0] data_out;
    logic        data_ready;

    int cycle = 0;
    int check_count = 0;
    int pass_count = 0;
    logic prev_ready = 1'b0;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    l1_sram_wrap dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csb        (csb),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .wmask      (wmask),
        .data_out   (data_out),
        .data_ready (data_ready)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: each rising data_ready must match the oldest outstanding read.
    always @(negedge clk) begin
        if (data_ready && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, data_out, e.data);
                check({e.name, "_latency"}, 32'(cycle), 32'(e.due));
            end
        end
        prev_ready <= data_ready;
    end

    task automatic apply_reset(input int n);
        rst_n = 1'b1;
        csb   = 1'b1;
        we    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic write_entry(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        csb     = 1'b0;
        we      = 1'b0;
        addr    = a;
        data_in = d;
        wmask   = m;
        @(posedge clk);
        #1;
        check("write_no_ready", 32'(data_ready), 32'd0);
        csb     = 1'b1;
        we      = 1'b1;
        addr    = ~a;
        data_in = ~d;
        @(posedge clk);
        #1;
    endtask

    // Issue a read, release csb, then wait (bounded) for completion.
    task automatic read_entry(input logic [8:0] a, input logic [31:0] expd, input string name);
        int waited;
        exp_t e;
        csb  = 1'b0;
        we   = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        e.data = expd;
        e.due  = cycle + 6;
        e.name = name;
        sb.push_back(e);
        csb     = 1'b1;
        we      = 1'b0;
        addr    = 9'h1FF;
        data_in = 32'hDEADBEEF;
        waited  = 0;
        while (!data_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({name, "_seen"}, 32'(data_ready), 32'd1);
        @(posedge clk);
        #1;
        check({name, "_drop"}, 32'(data_ready), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        csb = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        addr    = '0;
        data_in = '0;
        wmask   = '0;
        apply_reset(2);
        check("reset_ready", 32'(data_ready), 32'd0);
        check("reset_data", data_out, 32'd0);

        write_entry(9'd48, 32'd77, 4'b1111);
        write_entry(9'd49, 32'd1, 4'b1111);
        read_entry(9'd48, 32'd77, "rd48");

        write_entry(9'd5, 32'hAABBCCDD, 4'b1111);
        write_entry(9'd5, 32'h11223344, 4'b0101);
        read_entry(9'd5, 32'hAA22CC44, "partial");

        write_entry(9'd7, 32'h12345678, 4'b0011);
        read_entry(9'd7, 32'h00005678, "partial_invalid");

        read_entry(9'd48, 32'd77, "b2b_48");
        read_entry(9'd49, 32'd1, "b2b_49");
        check("hold_last_data", data_out, 32'd1);

        // Reset three clocks into a read: no completion may follow.
        csb  = 1'b0;
        we   = 1'b1;
        addr = 9'd48;
        @(posedge clk);
        #1;
        csb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        apply_reset(1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_ready", 32'(data_ready), 32'd0);
        check("abort_data", data_out, 32'd0);

        read_entry(9'd200, 32'd0, "unwritten");
        read_entry(9'd48, 32'd0, "cleared48");
        write_entry(9'd49, 32'h00C0FFEE, 4'b1111);

        // Held csb: one completion, ready persists until csb rises.
        begin
            exp_t e;
            csb  = 1'b0;
            we   = 1'b1;
            addr = 9'd49;
            @(posedge clk);
            #1;
            e.data = 32'h00C0FFEE;
            e.due  = cycle + 6;
            e.name = "held";
            sb.push_back(e);
            repeat (9) begin
                @(posedge clk);
                #1;
            end
            check("held_ready_high", 32'(data_ready), 32'd1);
            check("held_data", data_out, 32'h00C0FFEE);
            csb = 1'b1;
            @(posedge clk);
            #1;
            check("held_ready_drop", 32'(data_ready), 32'd0);
        end

        idle_cycles(4);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
